sar_search_controller: RTL and testbench
========================================

SAR_SEARCH_CONTROLLER -- requirements
Module: sar_search_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a search; sampled only in IDLE.
REQ-004 SHALL have port cmp_lt, input, 1 bit: external 20-bit comparator result, guess < target.
REQ-005 SHALL have port cmp_gt, input, 1 bit: external comparator result, guess > target.
REQ-006 SHALL have port cmp_eq, input, 1 bit: external comparator result, guess == target.
REQ-007 SHALL have port guess, output, 20 bits: registered trial value, driven to the comparator A input.
REQ-008 SHALL have port busy, output, 1 bit: high in PROBE and CHECK.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a search ends.
REQ-010 SHALL have port found, output, 1 bit: last search ended with cmp_eq.
REQ-011 SHALL have port error, output, 1 bit: last search aborted on an illegal comparator response.
REQ-012 SHALL have port result, output, 20 bits: final value of the last search.
REQ-013 SHALL have port steps, output, 5 bits: comparisons consumed by the last or current search (max 21).

Function
REQ-014 SHALL implement FSM states IDLE, PROBE, CHECK, DONE.
REQ-015 SHALL treat the comparator as combinational from guess, and sample cmp_* on the same clock edge at which guess is presented (one comparison per cycle).
REQ-016 In IDLE with start=1, SHALL clear accumulator, found, error and steps, set bit index 19 and guess=0x80000, and go to PROBE.
REQ-017 In PROBE, SHALL classify the response as legal only if exactly one of cmp_lt/cmp_gt/cmp_eq is 1; otherwise error=1, found=0, result=accumulator, go to DONE.
REQ-018 In PROBE, each legal response SHALL increment steps.
REQ-019 In PROBE, cmp_eq SHALL set found=1 and result=guess, and go to DONE (early exit).
REQ-020 In PROBE, cmp_lt SHALL keep the bit at the current index in the accumulator; cmp_gt SHALL clear it.
REQ-021 In PROBE with index > 0, after the keep/clear update SHALL decrement the index and set guess=accumulator with the next-lower bit set.
REQ-022 In PROBE with index 0, after the keep/clear update SHALL set guess=final accumulator and go to CHECK.
REQ-023 In CHECK, a legal response SHALL increment steps, set result=guess and found=cmp_eq, and go to DONE.
REQ-024 In CHECK, an illegal response SHALL apply the error rule of REQ-017.
REQ-025 In DONE, SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 result, found, error and steps SHALL hold their values until the next accepted start.
REQ-027 start while busy or in DONE SHALL be ignored, with no effect on the search.
REQ-028 guess SHALL hold its last value in IDLE and DONE.
REQ-029 Maximum latency SHALL be 22 cycles from the start edge to the done pulse (20 PROBE + 1 CHECK + DONE).
REQ-030 Minimum latency SHALL be 2 cycles (first-probe hit).

Reset
REQ-031 rst=1 SHALL force state IDLE and guess=0, busy=0, done=0, found=0, error=0, result=0, steps=0 at the next edge, including when asserted mid-search.
REQ-032 rst SHALL take priority over start; start asserted during the reset cycle SHALL be ignored.

Verification
REQ-033 Target 0x80000: model replies eq on the first probe -> done after 2 cycles, found=1, result=0x80000, steps=1.
REQ-034 Target 0x00000: 20 gt replies, then eq in CHECK -> found=1, result=0x00000, steps=21.
REQ-035 Target 0xFFFFF: 20 lt replies, then eq in CHECK -> found=1, result=0xFFFFF, steps=21.
REQ-036 Target 0x12345 with a reference comparator model -> found=1, result=0x12345, each guess matches the SAR sequence, done pulse lasts 1 cycle.
REQ-037 Illegal responses: all flags 0 at step 3 -> error=1, found=0, steps=2; repeat with lt=gt=1 -> same response.
REQ-038 Control corners: rst at step 10 -> all outputs 0 next cycle, state IDLE; new start then completes normally; start pulses while busy have no effect.

Source files
------------

// File: rtl/sar_search_controller.sv
// Successive-approximation search controller: drives a 20-bit trial value to an
// external comparator and resolves the target MSB-first, one comparison per cycle.
module sar_search_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cmp_lt,
  input  logic        cmp_gt,
  input  logic        cmp_eq,
  output logic [19:0] guess,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        error,
  output logic [19:0] result,
  output logic [4:0]  steps
);

  typedef enum logic [1:0] {IDLE, PROBE, CHECK, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [19:0] r_acc;
  logic [19:0] r_guess;
  logic [19:0] r_result;
  logic [4:0]  r_idx;
  logic [4:0]  r_steps;
  logic        r_found;
  logic        r_error;
  logic        w_legal;
  logic [19:0] w_acc_upd;
  logic [19:0] w_next_bit;

  // A comparator reply is trusted only when it is strictly one-hot.
  function automatic logic is_legal(input logic lt, input logic gt, input logic eq);
    return (lt & ~gt & ~eq) | (~lt & gt & ~eq) | (~lt & ~gt & eq);
  endfunction

  always_comb begin
    w_legal    = is_legal(cmp_lt, cmp_gt, cmp_eq);
    w_acc_upd  = r_acc;
    w_acc_upd[r_idx] = cmp_lt;
    w_next_bit = 20'h1 << (r_idx - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = PROBE;
      PROBE: begin
        if (!w_legal || cmp_eq) w_next = DONE;
        else if (r_idx == 5'd0) w_next = CHECK;
      end
      CHECK:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == PROBE) || (r_state == CHECK);
    done = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_guess  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_steps  <= '0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_found <= 1'b0;
            r_error <= 1'b0;
            r_steps <= '0;
            r_idx   <= 5'd19;
            r_guess <= 20'h80000;
          end
        end
        PROBE: begin
          if (!w_legal) begin
            r_error  <= 1'b1;
            r_found  <= 1'b0;
            r_result <= r_acc;
          end else begin
            r_steps <= r_steps + 5'd1;
            if (cmp_eq) begin
              r_found  <= 1'b1;
              r_result <= r_guess;
            end else begin
              r_acc <= w_acc_upd;
              // Last bit resolved: re-present the final accumulator for confirmation.
              if (r_idx != 5'd0) begin
                r_idx   <= r_idx - 5'd1;
                r_guess <= w_acc_upd | w_next_bit;
              end else begin
                r_guess <= w_acc_upd;
              end
            end
          end
        end
        CHECK: begin
          if (!w_legal) begin
            r_error  <= 1'b1;
            r_found  <= 1'b0;
            r_result <= r_acc;
          end else begin
            r_steps  <= r_steps + 5'd1;
            r_result <= r_guess;
            r_found  <= cmp_eq;
          end
        end
        default: ;
      endcase
    end
  end

  assign guess  = r_guess;
  assign found  = r_found;
  assign error  = r_error;
  assign result = r_result;
  assign steps  = r_steps;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench for sar_search_controller: a comparator model answers each guess,
// a SAR reference queues expected guesses and final results for comparison.
module tb_sar_search_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cmp_lt;
  logic        cmp_gt;
  logic        cmp_eq;
  logic [19:0] guess;
  logic        busy;
  logic        done;
  logic        found;
  logic        error;
  logic [19:0] result;
  logic [4:0]  steps;

  sar_search_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .error(error), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] result;
    logic        found;
    logic        error;
    logic [4:0]  steps;
    int          lat;
  } res_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [19:0] target = '0;
  int          mode = 0;      // 0: true comparator, 1: lt on every probe then eq
  int          inj_at = -1;   // comparison index (0-based) that gets an illegal reply
  int          inj_kind = 0;  // 0: all zero, 1: lt and gt together
  int          cmp_idx = 0;
  logic [19:0] q_guess[$];
  res_t        q_res[$];
  logic [19:0] last_g;

  function automatic logic [2:0] oracle(input logic [19:0] g, input int n,
                                        input logic [19:0] t, input int m,
                                        input int ia, input int ik);
    if (n == ia) return (ik == 0) ? 3'b000 : 3'b110;
    if (m == 1) return (n == 20) ? 3'b001 : 3'b100;
    return {g < t, g > t, g == t};
  endfunction

  always @(posedge clk) begin
    if (rst || !busy) cmp_idx <= 0;
    else              cmp_idx <= cmp_idx + 1;
  end

  always_comb begin
    {cmp_lt, cmp_gt, cmp_eq} = oracle(guess, cmp_idx, target, mode, inj_at, inj_kind);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [19:0] t, input int m, input int ia, input int ik);
    logic [19:0] acc = '0;
    logic [19:0] g;
    logic [2:0]  r;
    int          n = 0;
    bit          fin = 0;
    res_t        e;
    e.result = '0; e.found = 0; e.error = 0; e.steps = '0;
    for (int b = 19; b >= 0 && !fin; b--) begin
      g = acc | (20'h1 << b);
      q_guess.push_back(g);
      last_g = g;
      r = oracle(g, n, t, m, ia, ik);
      if (!(r == 3'b100 || r == 3'b010 || r == 3'b001)) begin
        e.error = 1; e.result = acc; fin = 1;
      end else begin
        n++;
        if (r[0]) begin e.found = 1; e.result = g; fin = 1; end
        else if (r[2]) acc = g;
      end
    end
    if (!fin) begin
      g = acc;
      q_guess.push_back(g);
      last_g = g;
      r = oracle(g, n, t, m, ia, ik);
      if (!(r == 3'b100 || r == 3'b010 || r == 3'b001)) begin
        e.error = 1; e.result = acc;
      end else begin
        n++; e.result = g; e.found = r[0];
      end
    end
    e.steps = 5'(n);
    e.lat = q_guess.size() + 1;
    q_res.push_back(e);
  endtask

  task automatic run(input logic [19:0] t, input int m, input int ia, input int ik,
                     input bit spam);
    int   lat = 0;
    bit   seen = 0;
    res_t e;
    target = t; mode = m; inj_at = ia; inj_kind = ik;
    model(t, m, ia, ik);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (spam) start = (c == 4);
      if (busy) begin
        if (q_guess.size() == 0) check("extra_guess", 32'(guess), 32'hFFFFFFFF);
        else check("guess", 32'(guess), 32'(q_guess.pop_front()));
      end
      if (done) begin lat = c; seen = 1; break; end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    e = q_res.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("result", 32'(result), 32'(e.result));
    check("found", 32'(found), 32'(e.found));
    check("error", 32'(error), 32'(e.error));
    check("steps", 32'(steps), 32'(e.steps));
    check("guess_q_empty", 32'(q_guess.size()), 32'd0);
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    check("result_hold", 32'(result), 32'(e.result));
    check("steps_hold", 32'(steps), 32'(e.steps));
    check("guess_hold", 32'(guess), 32'(last_g));
    q_guess.delete();
    q_res.delete();
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_guess"}, 32'(guess), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_found"}, 32'(found), 32'd0);
    check({pfx, "_error"}, 32'(error), 32'd0);
    check({pfx, "_result"}, 32'(result), 32'd0);
    check({pfx, "_steps"}, 32'(steps), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(20'h80000, 0, -1, 0, 0);
    run(20'h00000, 0, -1, 0, 0);
    run(20'hFFFFF, 1, -1, 0, 0);
    run(20'h12345, 0, -1, 0, 1);
    run(20'h12345, 0, 2, 0, 0);
    run(20'h12345, 0, 2, 1, 0);
    run(20'h00000, 0, 20, 0, 0);

    // Abort mid-search with start held high through the reset edge.
    target = 20'h12345; mode = 0; inj_at = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);
    @(negedge clk);
    check("still_idle", 32'(busy), 32'd0);

    run(20'h0A5A5, 0, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
